clock_invert_sequencer: RTL



---
 rtl/clock_ctl_pkg.sv | 19 +
 rtl/clock_invert_sequencer_if.sv | 13 +
 rtl/clkinv_settle_timer.sv | 38 +++
 rtl/clock_invert_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/clock_ctl_pkg.sv
// Shared definitions for the clock polarity sequencer: state encoding,
// parameter defaults and polarity constants.
package clock_ctl_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;

  // Defaults
  localparam int SETTLE_DEF = 3;
  localparam int CNT_W_DEF  = 8;

  // Polarity values carried on sel/phase/req_invert
  localparam logic POL_NORMAL = 1'b0;
  localparam logic POL_INVERT = 1'b1;

endpackage

// File: rtl/clock_invert_sequencer_if.sv
// Polarity request handshake between a requester and the sequencer.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. The requester holds req_valid and req_invert stable
// until that edge; req_ready does not depend on req_valid.
interface clock_invert_sequencer_if;
  logic req_valid;
  logic req_invert;
  logic req_ready;

  modport master (output req_valid, output req_invert, input req_ready);
  modport slave  (input req_valid, input req_invert, output req_ready);
endinterface

// File: rtl/clkinv_settle_timer.sv
// Loadable down-counter with a zero flag; times the settle phase after a
// sel transition. Load has priority over decrement; it stops at zero.
module clkinv_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, decrement toward zero, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clock_invert_sequencer.sv
// Owns the select line of the glitch-free clock invert mux. Accepts polarity
// requests, holds them while frozen, paces sel transitions SETTLE cycles apart
// and pulses done once the new polarity has settled at the mux output.
module clock_invert_sequencer
  import clock_ctl_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  clock_invert_sequencer_if.slave   req,
  input  logic                      freeze,
  output logic                      sel,
  output logic                      phase,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          switch_count,
  output state_t                    state_dbg
);

  // Settle counter only ever holds SETTLE-1 down to 0
  localparam int TW = (SETTLE > 2) ? $clog2(SETTLE) : 1;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             phase_q, phase_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;

  clkinv_settle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (TW'(SETTLE - 1)),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // FSM next state, sel launch, settle completion and transition counting
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    phase_d  = phase_q;
    done_d   = 1'b0;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          if (req.req_invert == phase_q) begin
            // Already at the requested polarity: acknowledge only
            done_d = 1'b1;
          end else if (freeze) begin
            pend_d  = req.req_invert;
            state_d = ST_WAIT;
          end else begin
            sel_d    = req.req_invert;
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!freeze) begin
          sel_d    = pend_q;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          phase_d = sel_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= POL_NORMAL;
      phase_q <= POL_NORMAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= POL_NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      phase_q <= phase_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req.req_ready = (state_q == ST_IDLE);
  assign sel           = sel_q;
  assign phase         = phase_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign switch_count  = cnt_q;
  assign state_dbg     = state_q;

endmodule
